if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 16-bit pipelined RISC core. Owns the 8-bit program counter.
//  Drives the asynchronous-read instruction memory address and captures the returned word.
//  Holds that word in the IF/ID pipeline register for the decode stage.
//  Supports decode-stage stall and branch redirect with flush.
// PARAMETERS
//  ADDR_WIDTH  8         PC / instruction-memory address width
//  DATA_WIDTH  16        instruction width
//  RESET_PC    8'h00     PC value loaded on reset
//  NOP_INSTR   16'hF000  bubble encoding placed in IF/ID on reset or flush (unused opcode 1111)
// PORTS
//  clk             in   1           rising-edge clock
//  rst_n           in   1           asynchronous, active-low reset
//  stall           in   1           hold PC and IF/ID (load-use / hazard stall from decode)
//  redirect_valid  in   1           taken branch/jump resolved downstream
//  redirect_pc     in   ADDR_WIDTH  branch target
//  imem_addr       out  ADDR_WIDTH  instruction-memory address, equal to PC (combinational)
//  imem_data       in   DATA_WIDTH  instruction word from memory, valid in the same cycle
//  ifid_instr      out  DATA_WIDTH  registered instruction for decode
//  ifid_pc         out  ADDR_WIDTH  address of ifid_instr
//  ifid_pc_plus1   out  ADDR_WIDTH  ifid_pc+1, mod 2^ADDR_WIDTH (branch-offset base)
//  ifid_valid      out  1           1 = ifid_instr is a real instruction, 0 = bubble
//  fetch_count     out  16          count of instructions accepted into IF/ID, saturating
// BEHAVIOUR
//  Clock and reset
//   - One clock (clk). Reset rst_n is asynchronous and active-low.
//   - While rst_n=0: pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus1=0,
//     ifid_valid=0, fetch_count=0.
//   - Reset asserted mid-operation clears state immediately. No partial instruction survives.
//  Memory interface
//   - imem_addr = pc at all times. imem_data is sampled at the same rising edge (zero-wait memory).
//  Per rising edge, by priority:
//   1. redirect_valid=1 (wins over stall):
//      - pc <= redirect_pc
//      - IF/ID <= bubble: instr=NOP_INSTR, valid=0; ifid_pc and ifid_pc_plus1 hold
//      - the wrong-path word on imem_data is discarded
//   2. stall=1:
//      - pc, IF/ID and fetch_count all hold
//      - imem_data is re-presented next cycle because pc is unchanged
//   3. otherwise:
//      - ifid_instr <= imem_data, ifid_pc <= pc, ifid_pc_plus1 <= pc+1, ifid_valid <= 1
//      - pc <= pc+1
//      - fetch_count <= fetch_count+1, saturating at 16'hFFFF
//  Latency and arithmetic
//   - An instruction at address A is on the ifid_* outputs one cycle after pc==A (no stall).
//   - pc+1 wraps modulo 2^ADDR_WIDTH: 8'hFF -> 8'h00. No overflow flag.
//  First cycle after reset release
//   - The first edge loads mem[RESET_PC] into IF/ID with valid=1.
//  Bubble handling
//   - A redirect to the current pc is legal: it still inserts one bubble.
//   - Back-to-back redirects each insert a bubble. The last target wins.
// STRUCTURE
//  Package fetch_pkg:
//   - ADDR_WIDTH and DATA_WIDTH localparams
//   - RESET_PC and NOP_INSTR constants
//   - packed struct ifid_t {instr, pc, pc_plus1, valid}, shared with the decode stage
//  Sub-module ifid_reg:
//   - ifid_t register with async-low reset, hold (stall) and bubble (flush) controls
//   - reusable for the ID/EX and EX/MEM stage registers
//  Top level: PC register, next-PC mux, saturating fetch counter.
// TESTING
//  Memory model: mem[0]=16'h0218 (ADD), mem[1]=16'hC441 (BEQ), mem[2]=16'h0418.
//  1. Reset then free-run 3 cycles
//     -> ifid_instr=0218/C441/0418, ifid_pc=0/1/2, ifid_valid=1, fetch_count=3.
//  2. Stall for 2 cycles while pc=1
//     -> imem_addr stays 1, IF/ID holds 0218 with pc 0, fetch_count holds.
//     -> C441 appears on the first edge after stall drops.
//  3. redirect_valid=1, redirect_pc=8'h05 while pc=2
//     -> next edge: ifid_valid=0, ifid_instr=F000, pc=5.
//     -> following edge: ifid_pc=5, ifid_valid=1.
//  4. stall=1 and redirect_valid=1 (redirect_pc=8'h07) together
//     -> redirect wins: pc=7, bubble inserted.
//  5. Force pc=8'hFF by redirect, then run
//     -> ifid_pc=FF, ifid_pc_plus1=00, next imem_addr=00.
//  6. Assert rst_n=0 asynchronously mid-cycle, during a stall
//     -> outputs reach reset values before the next edge.
//     -> after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: widths, reset constants and the IF/ID pipeline word.
package fetch_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 16;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC  = 8'h00;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 16'hF000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic                  valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{instr: NOP_INSTR, pc: '0, pc_plus1: '0, valid: 1'b0};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register for ifid_t with hold and bubble controls; bubble outranks hold.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_hold,
  input  logic  i_bubble,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  // A bubble keeps the address fields so downstream still sees the last fetched pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= IFID_RESET;
    end else if (i_bubble) begin
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and fetch counter.
module if_fetch_stage
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] ifid_instr,
  output logic [ADDR_WIDTH-1:0] ifid_pc,
  output logic [ADDR_WIDTH-1:0] ifid_pc_plus1,
  output logic                  ifid_valid,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CNT_WIDTH-1:0]  r_fetch_count;
  logic [ADDR_WIDTH-1:0] w_pc_plus1;
  logic                  w_advance;
  ifid_t                 w_ifid_d;
  ifid_t                 w_ifid_q;

  assign w_pc_plus1 = r_pc + 1'b1;
  assign w_advance  = !redirect_valid && !stall;

  // Redirect outranks stall so a resolved branch is never lost behind a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (!stall) begin
      r_pc <= w_pc_plus1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_advance) begin
      r_fetch_count <= sat_inc(r_fetch_count);
    end
  end

  assign w_ifid_d = '{instr: imem_data, pc: r_pc, pc_plus1: w_pc_plus1, valid: 1'b1};

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (stall),
    .i_bubble (redirect_valid),
    .i_d      (w_ifid_d),
    .o_q      (w_ifid_q)
  );

  assign imem_addr     = r_pc;
  assign ifid_instr    = w_ifid_q.instr;
  assign ifid_pc       = w_ifid_q.pc;
  assign ifid_pc_plus1 = w_ifid_q.pc_plus1;
  assign ifid_valid    = w_ifid_q.valid;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage against a zero-wait instruction memory.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic [7:0]  ifid_pc_plus1;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  int n_total = 0;
  int n_bad   = 0;

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus1  (ifid_pc_plus1),
    .ifid_valid     (ifid_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 16'h0218;
      8'h01:   return 16'hC441;
      8'h02:   return 16'h0418;
      default: return {8'hA0, a};
    endcase
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] instr, input logic [7:0] pc,
                         input logic [7:0] pc1, input logic vld, input logic [7:0] addr,
                         input logic [15:0] cnt);
    chk({tag, ".instr"}, 32'(ifid_instr), 32'(instr));
    chk({tag, ".pc"}, 32'(ifid_pc), 32'(pc));
    chk({tag, ".pc1"}, 32'(ifid_pc_plus1), 32'(pc1));
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(vld));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, ".cnt"}, 32'(fetch_count), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [7:0] rpc);
    @(negedge clk);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    chk_all("reset", 16'hF000, 8'h00, 8'h00, 1'b0, 8'h00, 16'd0);

    // Free run three fetches.
    @(negedge clk) rst_n = 1'b1;
    step(); chk_all("run1", 16'h0218, 8'h00, 8'h01, 1'b1, 8'h01, 16'd1);
    step(); chk_all("run2", 16'hC441, 8'h01, 8'h02, 1'b1, 8'h02, 16'd2);
    step(); chk_all("run3", 16'h0418, 8'h02, 8'h03, 1'b1, 8'h03, 16'd3);

    @(negedge clk) rst_n = 1'b0;
    #1 chk_all("reset2", 16'hF000, 8'h00, 8'h00, 1'b0, 8'h00, 16'd0);
    @(negedge clk) rst_n = 1'b1;

    // Stall while pc=1.
    step(); chk_all("pre_stall", 16'h0218, 8'h00, 8'h01, 1'b1, 8'h01, 16'd1);
    drive(1'b1, 1'b0, 8'h00);
    step(); chk_all("stall1", 16'h0218, 8'h00, 8'h01, 1'b1, 8'h01, 16'd1);
    step(); chk_all("stall2", 16'h0218, 8'h00, 8'h01, 1'b1, 8'h01, 16'd1);
    drive(1'b0, 1'b0, 8'h00);
    step(); chk_all("unstall", 16'hC441, 8'h01, 8'h02, 1'b1, 8'h02, 16'd2);

    // Redirect to 5 while pc=2.
    drive(1'b0, 1'b1, 8'h05);
    step(); chk_all("redir5", 16'hF000, 8'h01, 8'h02, 1'b0, 8'h05, 16'd2);
    drive(1'b0, 1'b0, 8'h00);
    step(); chk_all("after5", 16'hA005, 8'h05, 8'h06, 1'b1, 8'h06, 16'd3);

    // Redirect wins over stall, then back-to-back redirect to FF.
    drive(1'b1, 1'b1, 8'h07);
    step(); chk_all("redir7_stall", 16'hF000, 8'h05, 8'h06, 1'b0, 8'h07, 16'd3);
    drive(1'b0, 1'b1, 8'hFF);
    step(); chk_all("redirFF", 16'hF000, 8'h05, 8'h06, 1'b0, 8'hFF, 16'd3);
    drive(1'b0, 1'b0, 8'h00);
    step(); chk_all("wrap", 16'hA0FF, 8'hFF, 8'h00, 1'b1, 8'h00, 16'd4);

    // Redirect to the current pc still inserts one bubble.
    drive(1'b0, 1'b1, 8'h00);
    step(); chk_all("redir_self", 16'hF000, 8'hFF, 8'h00, 1'b0, 8'h00, 16'd4);
    drive(1'b0, 1'b0, 8'h00);
    step(); chk_all("after_self", 16'h0218, 8'h00, 8'h01, 1'b1, 8'h01, 16'd5);

    // Asynchronous reset mid-cycle during a stall.
    drive(1'b1, 1'b0, 8'h00);
    step(); chk_all("stall_pre_rst", 16'h0218, 8'h00, 8'h01, 1'b1, 8'h01, 16'd5);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 16'hF000, 8'h00, 8'h00, 1'b0, 8'h00, 16'd0);
    @(negedge clk) begin rst_n = 1'b1; stall = 1'b0; end
    step(); chk_all("restart", 16'h0218, 8'h00, 8'h01, 1'b1, 8'h01, 16'd1);

    // Counter saturation.
    repeat (65533) @(posedge clk);
    #1 chk("cnt_fffe", 32'(fetch_count), 32'h0000FFFE);
    step(); chk("cnt_ffff", 32'(fetch_count), 32'h0000FFFF);
    step(); chk("cnt_sat", 32'(fetch_count), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
